// File: rtl/fetch_hazard_ctrl.sv
// Front-end pipeline control: PC/IF-ID enables and flushes, ID/EX bubble, HALT, stall counter.
// Outputs are Mealy (same cycle as inputs); stalls hold PC and IF/ID, redirects win over all but HALT.
module fetch_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] id_instr_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        branch_taken_i,
    input  logic        imem_ready_i,
    input  logic        resume_i,
    output logic        pc_en_o,
    output logic        pc_load_o,
    output logic        ifid_en_o,
    output logic        ifid_flush_o,
    output logic        idex_bubble_o,
    output logic        halted_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_count_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        WAIT_MEM = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_q;
    logic        load_use;

    // XZR (r31) is never a real destination, so it cannot create a hazard.
    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd31) &&
                      ((ex_rd_i == id_instr_i[9:5]) || (ex_rd_i == id_instr_i[20:16]));

    always_comb begin
        pc_en_o       = 1'b1;
        pc_load_o     = 1'b0;
        ifid_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        halted_o      = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        if (state_q == HALT) begin
            halted_o      = 1'b1;
            idex_bubble_o = 1'b1;
            if (resume_i) begin
                ifid_flush_o = 1'b1;
                state_d      = RUN;
            end else begin
                pc_en_o   = 1'b0;
                ifid_en_o = 1'b0;
            end
        end else if (branch_taken_i) begin
            pc_load_o     = 1'b1;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            cnt_d         = FLUSH_LOAD;
            state_d       = (FLUSH_CYCLES > 0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (id_instr_i == HALT_WORD) begin
                        pc_en_o       = 1'b0;
                        ifid_en_o     = 1'b0;
                        idex_bubble_o = 1'b1;
                        state_d       = HALT;
                    end else if (load_use) begin
                        pc_en_o       = 1'b0;
                        ifid_en_o     = 1'b0;
                        idex_bubble_o = 1'b1;
                    end else if (!imem_ready_i) begin
                        pc_en_o      = 1'b0;
                        ifid_flush_o = 1'b1;
                        state_d      = WAIT_MEM;
                    end
                end
                FLUSH: begin
                    // Only cycles that actually return a word consume a flush slot.
                    ifid_flush_o = 1'b1;
                    if (imem_ready_i) begin
                        if (cnt_q <= 3'd1) begin
                            cnt_d   = 3'd0;
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (load_use) begin
                        pc_en_o       = 1'b0;
                        ifid_en_o     = 1'b0;
                        idex_bubble_o = 1'b1;
                    end else if (!imem_ready_i) begin
                        pc_en_o      = 1'b0;
                        ifid_flush_o = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        if (!rst_ni) begin
            pc_en_o       = 1'b0;
            pc_load_o     = 1'b0;
            ifid_en_o     = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
            halted_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_en_o && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign state_o       = state_q;
    assign stall_count_o = stall_q;

endmodule
